// File: rtl/avr_dmem_pkg.sv
// Shared constants, state encoding and decode helper for the avr_dmem data-memory responder.
package avr_dmem_pkg;

    // Peripheral page register addresses
    localparam logic [15:0] ADDR_GPIO_OUT = 16'h0020;
    localparam logic [15:0] ADDR_GPIO_IN  = 16'h0021;
    localparam logic [15:0] ADDR_ERR      = 16'h0022;

    // Data returned to the core when an external read times out
    localparam logic [7:0]  ERR_RDATA     = 8'hFF;

    // External bus sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } ext_state_e;

    // Half-open range test; 17-bit bounds so a window may end exactly at 16'hFFFF + 1
    function automatic logic in_range(input logic [15:0] a, input logic [16:0] lo, input logic [16:0] hi);
        return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
    endfunction

endpackage

// File: rtl/avr_dmem_if.sv
// CPU data port plus external bus of avr_dmem. The master side is the environment
// (core issuing addresses and the external device answering requests); slave is avr_dmem.
interface avr_dmem_if;
    logic [15:0] d_addr;
    logic [7:0]  data_out;
    logic        data_write;
    logic        d_read;
    logic [7:0]  data_in;
    logic        mem_wait;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic        ext_we;
    logic        ext_req;
    logic        ext_ack;
    logic [7:0]  ext_rdata;

    modport master (
        output d_addr, data_out, data_write, d_read, ext_ack, ext_rdata,
        input  data_in, mem_wait, ext_addr, ext_wdata, ext_we, ext_req
    );

    modport slave (
        input  d_addr, data_out, data_write, d_read, ext_ack, ext_rdata,
        output data_in, mem_wait, ext_addr, ext_wdata, ext_we, ext_req
    );
endinterface

// File: rtl/avr_sram.sv
// Single-port byte RAM, read-first, registered output. No reset on the array or the
// output register so the tools can map it onto a block RAM.
module avr_sram #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [7:0]               i_wdata,
    output logic [7:0]               o_rdata
);
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    // Read-first port: the read samples the array before this edge's write lands
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/avr_dmem.sv
// avr_dmem: data-memory responder for avr_cpu. Decodes the core's data address into a
// peripheral page, an internal SRAM and an external window served by a REQ/ack sequencer
// with timeout. Read data is returned one cycle after the address.
module avr_dmem
    import avr_dmem_pkg::*;
#(
    parameter logic [15:0] SRAM_BASE  = 16'h0100,
    parameter int          SRAM_DEPTH = 1024,
    parameter logic [15:0] EXT_BASE   = 16'h8000,
    parameter int          TIMEOUT    = 255
) (
    input  logic       CLK,
    input  logic       RST,
    avr_dmem_if.slave  bus,
    input  logic [7:0] gpio_in,
    output logic [7:0] gpio_out,
    output logic       bus_err
);
    localparam int              AW       = $clog2(SRAM_DEPTH);
    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam logic [16:0]     SRAM_END = {1'b0, SRAM_BASE} + 17'(SRAM_DEPTH);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(TIMEOUT);

    ext_state_e     r_state;
    ext_state_e     w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic           r_ext_req;
    logic           r_ext_we;
    logic [15:0]    r_ext_addr;
    logic [7:0]     r_ext_wdata;
    logic [7:0]     r_data;
    logic           r_use_sram;
    logic [7:0]     r_gpio_out;
    logic [7:0]     r_gpio_s1;
    logic [7:0]     r_gpio_s2;
    logic           r_bus_err;

    logic           w_in_sram;
    logic           w_in_ext;
    logic           w_launch;
    logic           w_ack;
    logic           w_timeout;
    logic           w_sram_we;
    logic [AW-1:0]  w_sram_idx;
    logic [7:0]     w_sram_rdata;
    logic [7:0]     w_periph_rdata;
    logic [7:0]     w_data_in;

    // Address decode
    assign w_in_ext   = (bus.d_addr >= EXT_BASE);
    assign w_in_sram  = in_range(bus.d_addr, {1'b0, SRAM_BASE}, SRAM_END);
    assign w_sram_idx = AW'(bus.d_addr - SRAM_BASE);
    assign w_sram_we  = bus.data_write & w_in_sram;
    assign w_launch   = (r_state == ST_IDLE) & w_in_ext & (bus.d_read | bus.data_write);

    avr_sram #(
        .DEPTH (SRAM_DEPTH)
    ) u_sram (
        .clk     (CLK),
        .i_we    (w_sram_we),
        .i_addr  (w_sram_idx),
        .i_wdata (bus.data_out),
        .o_rdata (w_sram_rdata)
    );

    // Peripheral page read mux; unmapped low addresses and the gap read as zero
    always_comb begin
        w_periph_rdata = 8'h00;
        case (bus.d_addr)
            ADDR_GPIO_OUT: w_periph_rdata = r_gpio_out;
            ADDR_GPIO_IN:  w_periph_rdata = r_gpio_s2;
            ADDR_ERR:      w_periph_rdata = {7'b0000000, r_bus_err};
            default:       w_periph_rdata = 8'h00;
        endcase
    end

    // External sequencer next state; ack takes priority over a coincident timeout
    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.ext_ack) begin
                    w_ack       = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (r_cnt == CNT_MAX) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Sequencer state, timeout counter and latched external request
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ext_req   <= 1'b0;
            r_ext_we    <= 1'b0;
            r_ext_addr  <= 16'h0000;
            r_ext_wdata <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_ext_req <= (w_state_nxt == ST_REQ);
            if (w_launch) begin
                r_cnt       <= '0;
                r_ext_addr  <= bus.d_addr;
                r_ext_wdata <= bus.data_out;
                r_ext_we    <= bus.data_write;
            end else if ((r_state == ST_REQ) && (w_state_nxt == ST_REQ)) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Read-data register: reloaded every cycle from internal decode, held across external accesses
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_data     <= 8'h00;
            r_use_sram <= 1'b0;
        end else if (r_state == ST_REQ) begin
            r_use_sram <= 1'b0;
            if (w_ack && !r_ext_we) begin
                r_data <= bus.ext_rdata;
            end else if (w_timeout && !r_ext_we) begin
                r_data <= ERR_RDATA;
            end else begin
                r_data <= w_data_in;
            end
        end else if (w_in_ext) begin
            r_use_sram <= 1'b0;
            r_data     <= w_data_in;
        end else if (w_in_sram) begin
            r_use_sram <= 1'b1;
        end else begin
            r_use_sram <= 1'b0;
            r_data     <= w_periph_rdata;
        end
    end

    // GPIO output port, input synchroniser and sticky error flag (timeout beats clear)
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_gpio_out <= 8'h00;
            r_gpio_s1  <= 8'h00;
            r_gpio_s2  <= 8'h00;
            r_bus_err  <= 1'b0;
        end else begin
            r_gpio_s1 <= gpio_in;
            r_gpio_s2 <= r_gpio_s1;
            if (bus.data_write && (bus.d_addr == ADDR_GPIO_OUT)) begin
                r_gpio_out <= bus.data_out;
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end else if (bus.data_write && (bus.d_addr == ADDR_ERR) && bus.data_out[0]) begin
                r_bus_err <= 1'b0;
            end
        end
    end

    // SRAM output register is selected directly so internal reads keep single-cycle latency
    assign w_data_in     = r_use_sram ? w_sram_rdata : r_data;
    assign bus.data_in   = w_data_in;
    // Combinational so the core stalls in the launch cycle; forced low while in reset
    assign bus.mem_wait  = RST & (w_launch | (r_state == ST_REQ));
    assign bus.ext_req   = r_ext_req;
    assign bus.ext_we    = r_ext_we;
    assign bus.ext_addr  = r_ext_addr;
    assign bus.ext_wdata = r_ext_wdata;
    assign gpio_out      = r_gpio_out;
    assign bus_err       = r_bus_err;

endmodule

// File: tb/tb_avr_dmem.sv
// Self-checking bench for avr_dmem: randomized accesses against a behavioural memory-map
// model; expected read data goes into a scoreboard queue drained by an independent monitor.
module tb_avr_dmem;
    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] gpio_in;
    logic [7:0] gpio_out;
    logic       bus_err;

    avr_dmem_if v ();

    avr_dmem #(
        .SRAM_BASE  (16'h0100),
        .SRAM_DEPTH (1024),
        .EXT_BASE   (16'h8000),
        .TIMEOUT    (TMO)
    ) dut (
        .CLK      (clk),
        .RST      (rst_n),
        .bus      (v.slave),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;

    // Behavioural model of the visible memory map
    logic [7:0] m_sram [0:1023];
    logic [7:0] m_gpio_out = 8'h00;
    logic [7:0] m_gpio_in  = 8'h00;
    logic       m_bus_err  = 1'b0;

    task automatic chk(input bit ok, input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [15:0] a);
        logic [15:0] off;
        off = a - 16'h0100;
        if (a >= 16'h0100 && a < 16'h0500) return m_sram[off[9:0]];
        if (a == 16'h0020) return m_gpio_out;
        if (a == 16'h0021) return m_gpio_in;
        if (a == 16'h0022) return {7'd0, m_bus_err};
        return 8'h00;
    endfunction

    function automatic void model_write(input logic [15:0] a, input logic [7:0] d);
        logic [15:0] off;
        off = a - 16'h0100;
        if (a >= 16'h0100 && a < 16'h0500) m_sram[off[9:0]] = d;
        else if (a == 16'h0020) m_gpio_out = d;
        else if (a == 16'h0022 && d[0]) m_bus_err = 1'b0;
    endfunction

    // Monitor: a read retires either one cycle after an internal read or at REQ->DONE
    initial begin : monitor
        bit   pend_rd;
        bit   prev_req;
        bit   prev_we;
        exp_t e;
        pend_rd = 0; prev_req = 0; prev_we = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend_rd = 0; prev_req = 0; prev_we = 0;
            end else begin
                if (pend_rd || (prev_req && !v.ext_req && !prev_we)) begin
                    if (sb_q.size() == 0) begin
                        chk(1'b0, "sb_unexpected_read", {8'h00, v.data_in}, 16'h0000);
                    end else begin
                        e = sb_q.pop_front();
                        chk(v.data_in === e.d, $sformatf("data_in@%h", e.a), {8'h00, v.data_in}, {8'h00, e.d});
                    end
                end
                pend_rd  = v.d_read && (v.d_addr < 16'h8000) && !v.mem_wait;
                prev_req = v.ext_req;
                prev_we  = v.ext_we;
            end
        end
    end

    // All driver tasks start and return 1 time unit after a rising edge
    task automatic idle(input int n);
        v.d_read = 1'b0; v.data_write = 1'b0; v.d_addr = 16'h0000;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic int_op(input logic [15:0] a, input logic rd, input logic wr, input logic [7:0] wd);
        v.d_addr = a; v.d_read = rd; v.data_write = wr; v.data_out = wd;
        if (rd) sb_q.push_back('{a, model_read(a)});
        @(negedge clk);
        chk(v.mem_wait === 1'b0, "int_mem_wait", {15'd0, v.mem_wait}, 16'h0000);
        chk(gpio_out === m_gpio_out, "gpio_out", {8'h00, gpio_out}, {8'h00, m_gpio_out});
        chk(bus_err === m_bus_err, "bus_err", {15'd0, bus_err}, {15'd0, m_bus_err});
        if (wr) model_write(a, wd);
        @(posedge clk); #1;
        v.d_read = 1'b0; v.data_write = 1'b0;
    endtask

    task automatic set_gpio(input logic [7:0] val);
        gpio_in = val;
        idle(2);
        m_gpio_in = val;
    endtask

    // k = REQ cycle carrying ext_ack (1-based), 0 = never acknowledged
    task automatic ext_access(input logic [15:0] a, input logic we, input logic [7:0] wd,
                              input int k, input logic [7:0] rd);
        int waits;
        int exp_waits;
        bit done;
        bit stable;
        waits = 0; done = 0; stable = 1;
        exp_waits = (k > 0) ? k + 1 : TMO + 2;
        v.d_addr = a; v.d_read = !we; v.data_write = we; v.data_out = wd;
        if (!we) sb_q.push_back('{a, (k > 0) ? rd : 8'hFF});
        for (int cyc = 0; cyc <= TMO + 8; cyc++) begin
            v.ext_ack   = (k > 0 && cyc == k) ? 1'b1 : ((cyc == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
            v.ext_rdata = (cyc == k) ? rd : 8'($urandom);
            @(negedge clk);
            if (!v.mem_wait) begin
                done = 1;
                break;
            end
            waits++;
            if (cyc > 0 && !(v.ext_req === 1'b1 && v.ext_addr === a && v.ext_we === we &&
                             (!we || v.ext_wdata === wd))) stable = 0;
            @(posedge clk); #1;
        end
        v.ext_ack = 1'b0;
        chk(done, "ext_done_bound", {15'd0, done}, 16'h0001);
        chk(waits == exp_waits, "mem_wait_cycles", 16'(waits), 16'(exp_waits));
        chk(stable, "ext_req_stable", {15'd0, stable}, 16'h0001);
        if (k == 0) m_bus_err = 1'b1;
        @(posedge clk); #1;
        v.d_read = 1'b0; v.data_write = 1'b0;
        @(negedge clk);
        chk(v.ext_req === 1'b0, "no_relaunch", {15'd0, v.ext_req}, 16'h0000);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        rst_n = 1'b0; gpio_in = 8'h00;
        v.d_addr = 16'h0000; v.data_out = 8'h00; v.data_write = 1'b0; v.d_read = 1'b0;
        v.ext_ack = 1'b0; v.ext_rdata = 8'h00;
        #12;
        chk(v.data_in === 8'h00, "rst_data_in", {8'h00, v.data_in}, 16'h0000);
        chk(gpio_out === 8'h00, "rst_gpio_out", {8'h00, gpio_out}, 16'h0000);
        chk(bus_err === 1'b0, "rst_bus_err", {15'd0, bus_err}, 16'h0000);
        chk(v.ext_req === 1'b0, "rst_ext_req", {15'd0, v.ext_req}, 16'h0000);
        chk(v.ext_we === 1'b0, "rst_ext_we", {15'd0, v.ext_we}, 16'h0000);
        chk(v.ext_addr === 16'h0000, "rst_ext_addr", v.ext_addr, 16'h0000);
        chk(v.ext_wdata === 8'h00, "rst_ext_wdata", {8'h00, v.ext_wdata}, 16'h0000);
        chk(v.mem_wait === 1'b0, "rst_mem_wait", {15'd0, v.mem_wait}, 16'h0000);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        idle(2);

        for (int i = 0; i < 1024; i++) int_op(16'h0100 + 16'(i), 1'b0, 1'b1, 8'($urandom));

        // SRAM round trip
        int_op(16'h0100, 1'b0, 1'b1, 8'hA5);
        int_op(16'h0100, 1'b1, 1'b0, 8'h00);
        // Read-first collision
        int_op(16'h0105, 1'b0, 1'b1, 8'h11);
        int_op(16'h0105, 1'b1, 1'b1, 8'h22);
        int_op(16'h0105, 1'b1, 1'b0, 8'h00);
        // External read acknowledged in the 3rd REQ cycle
        ext_access(16'h8004, 1'b0, 8'h00, 3, 8'h5C);
        // Timeout, then clear the error flag
        ext_access(16'h9000, 1'b0, 8'h00, 0, 8'h00);
        int_op(16'h0022, 1'b1, 1'b0, 8'h00);
        int_op(16'h0022, 1'b0, 1'b1, 8'h01);
        int_op(16'h0022, 1'b1, 1'b0, 8'h00);
        // GPIO
        int_op(16'h0020, 1'b0, 1'b1, 8'h3C);
        set_gpio(8'h81);
        int_op(16'h0021, 1'b1, 1'b0, 8'h00);
        int_op(16'h0020, 1'b1, 1'b0, 8'h00);

        // Reset in the middle of an external request
        int_op(16'h0110, 1'b0, 1'b1, 8'h5A);
        int_op(16'h0110, 1'b1, 1'b0, 8'h00);
        v.d_addr = 16'hA000; v.d_read = 1'b1; v.ext_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        chk(v.ext_req === 1'b1, "pre_rst_ext_req", {15'd0, v.ext_req}, 16'h0001);
        chk(v.data_in === 8'h5A, "req_hold_data_in", {8'h00, v.data_in}, 16'h005A);
        rst_n = 1'b0;
        #1;
        chk(v.ext_req === 1'b0, "rst_async_ext_req", {15'd0, v.ext_req}, 16'h0000);
        chk(v.mem_wait === 1'b0, "rst_async_mem_wait", {15'd0, v.mem_wait}, 16'h0000);
        chk(v.data_in === 8'h00, "rst_async_data_in", {8'h00, v.data_in}, 16'h0000);
        sb_q.delete();
        m_gpio_out = 8'h00; m_bus_err = 1'b0;
        v.d_read = 1'b0; v.d_addr = 16'h0000;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        idle(2);
        int_op(16'h0110, 1'b1, 1'b0, 8'h00);
        int_op(16'h0020, 1'b1, 1'b0, 8'h00);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int          r;
            logic [15:0] a;
            r = $urandom_range(0, 99);
            a = 16'($urandom_range(16'h0100, 16'h04FF));
            if (r < 30) begin
                int_op(a, 1'b1, 1'b0, 8'h00);
            end else if (r < 45) begin
                int_op(a, 1'b0, 1'b1, 8'($urandom));
            end else if (r < 52) begin
                int_op(a, 1'b1, 1'b1, 8'($urandom));
            end else if (r < 62) begin
                case ($urandom_range(0, 4))
                    0:       a = 16'h0020;
                    1:       a = 16'h0021;
                    2:       a = 16'h0022;
                    3:       a = 16'($urandom_range(0, 255));
                    default: a = 16'($urandom_range(16'h0500, 16'h7FFF));
                endcase
                int_op(a, 1'b1, 1'b0, 8'h00);
            end else if (r < 70) begin
                case ($urandom_range(0, 2))
                    0:       a = 16'h0020;
                    1:       a = 16'h0021;
                    default: a = 16'h0022;
                endcase
                int_op(a, 1'b0, 1'b1, 8'($urandom));
            end else if (r < 90) begin
                a = 16'($urandom_range(16'h8000, 16'hFFFF));
                ext_access(a, 1'($urandom_range(0, 1)), 8'($urandom),
                           ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TMO + 1)),
                           8'($urandom));
            end else begin
                set_gpio(8'($urandom));
            end
        end

        idle(3);
        chk(sb_q.size() == 0, "sb_drain", 16'(sb_q.size()), 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
